// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between the instruction-fetch
// port and the load/store data port. One transaction is in flight at a time.
// A transaction is granted in IDLE and its response is returned during the one-cycle RESP state.
// Word addresses at or beyond MEM_WORDS are accepted, but they never reach memory.
// Their response carries an error flag instead.
// Optional feature macro: MEM_ARB_RR_EN
//    defined   -> round-robin arbitration between the two ports
//    undefined -> fixed priority, the data port always wins
module mem_arbiter #(
   parameter int MEM_WORDS = 1536,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             if_valid,
   input  logic [31:0]      if_addr,
   output logic             if_ready,
   output logic             if_rsp_valid,
   output logic [31:0]      if_rsp_rdata,
   output logic             if_rsp_err,

   input  logic             d_valid,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   input  logic [3:0]       d_wmask,
   output logic             d_ready,
   output logic             d_rsp_valid,
   output logic [31:0]      d_rsp_rdata,
   output logic             d_rsp_err,

   output logic [31:0]      mem_addr,
   output logic             mem_rstrb,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wmask,
   input  logic [31:0]      mem_rdata,

   output logic [CNT_W-1:0] if_grant_cnt,
   output logic [CNT_W-1:0] d_grant_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   logic [0:0]  state;

   logic        grant_if;
   logic        grant_d;
   logic        grant_any;
   logic [31:0] win_addr;
   logic        win_write;
   logic        win_in_range;

   // Captured at the grant so the RESP cycle knows whom to answer and how.
   logic        rsp_port;
   logic        rsp_err;
   logic        rsp_read;
   logic        rsp_active;
   logic [31:0] rsp_data;

`ifdef MEM_ARB_RR_EN
   logic        last_grant;
`endif

   // A word index is addr[31:2]; anything at or past MEM_WORDS has no backing storage.
   function automatic logic addr_in_range(input logic [31:0] addr);
      return {2'b00, addr[31:2]} < 32'(MEM_WORDS);
   endfunction

   // Pick the winner for this cycle; grants only happen in IDLE and never while reset is high.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (!reset && state == ST_IDLE) begin
`ifdef MEM_ARB_RR_EN
         if (if_valid && d_valid) begin
            if (last_grant == PORT_IF) begin
               grant_d = 1'b1;
            end else begin
               grant_if = 1'b1;
            end
         end else begin
            grant_if = if_valid;
            grant_d  = d_valid;
         end
`else
         grant_d  = d_valid;
         grant_if = if_valid && !d_valid;
`endif
      end
   end

   assign grant_any = grant_if || grant_d;
   assign if_ready  = grant_if;
   assign d_ready   = grant_d;

   // Steer the winner onto the memory port; out-of-range requests keep both strobes low.
   always_comb begin
      win_addr     = 32'h0;
      win_write    = 1'b0;
      win_in_range = 1'b0;
      mem_addr     = 32'h0;
      mem_rstrb    = 1'b0;
      mem_wmask    = 4'b0000;
      mem_wdata    = 32'h0;
      if (grant_any) begin
         win_addr     = grant_d ? d_addr : if_addr;
         win_write    = grant_d && (d_wmask != 4'b0000);
         win_in_range = addr_in_range(win_addr);
         mem_addr     = win_addr;
         if (win_write) begin
            mem_wdata = d_wdata;
         end
         if (win_in_range) begin
            if (win_write) begin
               mem_wmask = d_wmask;
            end else begin
               mem_rstrb = 1'b1;
            end
         end
      end
   end

   // Two-state sequencer: a grant always buys exactly one RESP cycle, then back to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else if (state == ST_RESP) begin
         state <= ST_IDLE;
      end else if (grant_any) begin
         state <= ST_RESP;
      end
   end

   // Remember who was granted and what kind of answer the RESP cycle owes them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_port <= PORT_IF;
         rsp_err  <= 1'b0;
         rsp_read <= 1'b0;
      end else if (grant_any) begin
         rsp_port <= grant_d ? PORT_D : PORT_IF;
         rsp_err  <= !win_in_range;
         rsp_read <= !win_write;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Track the last winner so contention alternates between the ports.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_IF;
      end else if (grant_d) begin
         last_grant <= PORT_D;
      end else if (grant_if) begin
         last_grant <= PORT_IF;
      end
   end
`endif

   // Per-port accepted-request counters, including error requests, wrapping naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_grant_cnt <= '0;
         d_grant_cnt  <= '0;
      end else begin
         if (grant_if) begin
            if_grant_cnt <= if_grant_cnt + CNT_W'(1);
         end
         if (grant_d) begin
            d_grant_cnt <= d_grant_cnt + CNT_W'(1);
         end
      end
   end

   // Memory read data is valid during RESP; writes and errors answer with zero.
   always_comb begin
      rsp_active   = (state == ST_RESP) && !reset;
      rsp_data     = (rsp_read && !rsp_err) ? mem_rdata : 32'h0;
      if_rsp_valid = 1'b0;
      d_rsp_valid  = 1'b0;
      if_rsp_rdata = 32'h0;
      d_rsp_rdata  = 32'h0;
      if_rsp_err   = 1'b0;
      d_rsp_err    = 1'b0;
      if (rsp_active) begin
         if (rsp_port == PORT_D) begin
            d_rsp_valid = 1'b1;
            d_rsp_rdata = rsp_data;
            d_rsp_err   = rsp_err;
         end else begin
            if_rsp_valid = 1'b1;
            if_rsp_rdata = rsp_data;
            if_rsp_err   = rsp_err;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random two-port traffic.
// A transaction-level reference model is used.
// It keeps its own copy of memory contents and grant counts, and it predicts every cycle of the arbiter.
module tb_mem_arbiter;

   localparam int MEM_WORDS = 1536;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_rdata;
   logic        if_rsp_err;
   logic        d_valid;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wmask;
   logic        d_ready;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_rdata;
   logic        d_rsp_err;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] if_grant_cnt;
   logic [31:0] d_grant_cnt;

   mem_arbiter #(.MEM_WORDS(MEM_WORDS), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
      .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_ready(d_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .d_rsp_err(d_rsp_err),
      .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
      .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural Memory: registered read on rstrb, byte-masked write.
   logic [31:0] env_mem [0:MEM_WORDS-1];
   always @(posedge clk) begin
      if (mem_addr[31:2] < 30'(MEM_WORDS)) begin
         if (mem_rstrb) mem_rdata <= env_mem[mem_addr[12:2]];
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) env_mem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:MEM_WORDS-1];
   logic [31:0] m_if_cnt, m_d_cnt;
   bit          m_busy;
   bit          m_port_d;
   bit          m_err;
   logic [31:0] m_rdata;
   bit          m_last_d;
   bit          grant_log[$];
   bit          if_acc, d_acc;
   int          n_cmp = 0;
   int          n_fail = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] w;
      int r;
      r = $urandom_range(19);
      if (r == 0)      w = 32'(MEM_WORDS) + 32'($urandom_range(40));
      else if (r == 1) w = 32'($urandom);
      else             w = 32'($urandom_range(15));
      return {w[29:0], 2'($urandom_range(3))};
   endfunction

   // Random requesters: hold a request until accepted, occasionally withdraw it.
   task automatic applyStimulus();
      if (if_acc || !if_valid) begin
         if_valid = ($urandom_range(2) != 0);
         if_addr  = randAddr();
      end else if ($urandom_range(9) == 0) begin
         if_valid = 1'b0;
      end
      if (d_acc || !d_valid) begin
         d_valid = ($urandom_range(2) != 0);
         d_addr  = randAddr();
         d_wdata = $urandom;
         d_wmask = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom_range(15));
      end else if ($urandom_range(9) == 0) begin
         d_valid = 1'b0;
      end
   endtask

   // Predict this cycle from the transaction rules and compare everything visible.
   task automatic modelCheck();
      bit          w_d, w_if, is_wr;
      logic [31:0] addr, idx;
      if_acc = 0;
      d_acc  = 0;
      checkOutput("if_cnt", if_grant_cnt, m_if_cnt);
      checkOutput("d_cnt", d_grant_cnt, m_d_cnt);
      if (m_busy) begin
         checkOutput("rsp_if_ready", 32'(if_ready), 0);
         checkOutput("rsp_d_ready", 32'(d_ready), 0);
         checkOutput("rsp_rstrb", 32'(mem_rstrb), 0);
         checkOutput("rsp_wmask", 32'(mem_wmask), 0);
         checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'(!m_port_d));
         checkOutput("d_rsp_valid", 32'(d_rsp_valid), 32'(m_port_d));
         if (m_port_d) begin
            checkOutput("d_rsp_err", 32'(d_rsp_err), 32'(m_err));
            checkOutput("d_rsp_rdata", d_rsp_rdata, m_rdata);
         end else begin
            checkOutput("if_rsp_err", 32'(if_rsp_err), 32'(m_err));
            checkOutput("if_rsp_rdata", if_rsp_rdata, m_rdata);
         end
         m_busy = 0;
      end else begin
         checkOutput("idle_if_rsp_valid", 32'(if_rsp_valid), 0);
         checkOutput("idle_d_rsp_valid", 32'(d_rsp_valid), 0);
         w_d  = 0;
         w_if = 0;
         if (d_valid && if_valid) begin
`ifdef MEM_ARB_RR_EN
            w_d = !m_last_d;
`else
            w_d = 1;
`endif
            w_if = !w_d;
         end else begin
            w_d  = d_valid;
            w_if = if_valid;
         end
         checkOutput("if_ready", 32'(if_ready), 32'(w_if));
         checkOutput("d_ready", 32'(d_ready), 32'(w_d));
         if (!w_d && !w_if) begin
            checkOutput("idle_rstrb", 32'(mem_rstrb), 0);
            checkOutput("idle_wmask", 32'(mem_wmask), 0);
            checkOutput("idle_wdata", mem_wdata, 0);
         end else begin
            addr  = w_d ? d_addr : if_addr;
            idx   = addr >> 2;
            is_wr = w_d && (d_wmask != 4'b0000);
            m_err = (idx >= 32'(MEM_WORDS));
            checkOutput("mem_addr", mem_addr, addr);
            checkOutput("mem_rstrb", 32'(mem_rstrb), 32'(!is_wr && !m_err));
            checkOutput("mem_wmask", 32'(mem_wmask), (is_wr && !m_err) ? 32'(d_wmask) : 0);
            checkOutput("mem_wdata", mem_wdata, is_wr ? d_wdata : 0);
            m_rdata = 32'h0;
            if (!m_err && !is_wr) m_rdata = ref_mem[idx[10:0]];
            if (!m_err && is_wr)
               for (int b = 0; b < 4; b++)
                  if (d_wmask[b]) ref_mem[idx[10:0]][8*b +: 8] = d_wdata[8*b +: 8];
            m_port_d = w_d;
            m_busy   = 1;
            m_last_d = w_d;
            if (w_d) m_d_cnt++; else m_if_cnt++;
            grant_log.push_back(w_d);
            if_acc = w_if;
            d_acc  = w_d;
         end
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      modelCheck();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      m_busy   = 0;
      m_if_cnt = 0;
      m_d_cnt  = 0;
      m_last_d = 0;
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) begin
         logic [31:0] v;
         v = 32'($urandom);
         if (i == 5) v = 32'hDEADBEEF;
         if (i == 8) v = 32'h11223344;
         env_mem[i] <= v;
         ref_mem[i] = v;
      end
      modelReset();
      if_acc   = 0;
      d_acc    = 0;

      // Reset: readies and strobes forced low even with requests pending.
      reset    = 1'b1;
      if_valid = 1'b1;
      if_addr  = 32'h14;
      d_valid  = 1'b1;
      d_addr   = 32'h20;
      d_wdata  = 32'h0;
      d_wmask  = 4'b1111;
      @(negedge clk);
      checkOutput("reset_if_ready", 32'(if_ready), 0);
      checkOutput("reset_d_ready", 32'(d_ready), 0);
      checkOutput("reset_rstrb", 32'(mem_rstrb), 0);
      checkOutput("reset_wmask", 32'(mem_wmask), 0);
      checkOutput("reset_rsp_valid", {30'h0, if_rsp_valid, d_rsp_valid}, 0);
      checkOutput("reset_rdata", if_rsp_rdata | d_rsp_rdata, 0);
      checkOutput("reset_if_cnt", if_grant_cnt, 0);
      checkOutput("reset_d_cnt", d_grant_cnt, 0);
      if_valid = 1'b0;
      d_valid  = 1'b0;
      reset    = 1'b0;
      @(posedge clk);
      #1;

      // Fetch read of word 5.
      if_valid = 1'b1;
      if_addr  = 32'h14;
      stepCycle();
      if_valid = 1'b0;
      checkOutput("tp_read_valid", 32'(if_rsp_valid), 1);
      checkOutput("tp_read_data", if_rsp_rdata, 32'hDEADBEEF);
      stepCycle();

      // Byte write into word 8, then read it back.
      d_valid = 1'b1;
      d_addr  = 32'h20;
      d_wmask = 4'b0100;
      d_wdata = 32'h00AB0000;
      stepCycle();
      d_valid = 1'b0;
      checkOutput("tp_write_ack", 32'(d_rsp_valid), 1);
      checkOutput("tp_write_rdata", d_rsp_rdata, 0);
      stepCycle();
      d_valid = 1'b1;
      d_wmask = 4'b0000;
      stepCycle();
      d_valid = 1'b0;
      checkOutput("tp_readback", d_rsp_rdata, 32'h11AB3344);
      stepCycle();

      // Out-of-range data read at word 1536.
      d_valid = 1'b1;
      d_addr  = 32'h1800;
      stepCycle();
      d_valid = 1'b0;
      checkOutput("tp_oor_err", 32'(d_rsp_err), 1);
      checkOutput("tp_oor_rdata", d_rsp_rdata, 0);
      stepCycle();
      checkOutput("tp_oor_cnt", d_grant_cnt, 3);

      // Reset asserted while a response is being returned.
      d_valid = 1'b1;
      d_addr  = 32'hC;
      stepCycle();
      d_valid = 1'b0;
      checkOutput("tp_pre_reset_rsp", 32'(d_rsp_valid), 1);
      reset = 1'b1;
      #1;
      checkOutput("tp_reset_drops_rsp", 32'(d_rsp_valid), 0);
      checkOutput("tp_reset_if_cnt", if_grant_cnt, 0);
      checkOutput("tp_reset_d_cnt", d_grant_cnt, 0);
      modelReset();
      if_valid = 1'b1;
      d_valid  = 1'b1;
      @(negedge clk);
      checkOutput("tp_reset_ready", {30'h0, if_ready, d_ready}, 0);
      if_valid = 1'b0;
      d_valid  = 1'b0;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      if_valid = 1'b1;
      if_addr  = 32'h14;
      stepCycle();
      if_valid = 1'b0;
      checkOutput("tp_after_reset_data", if_rsp_rdata, 32'hDEADBEEF);
      stepCycle();
      if_valid = 1'b1;
      if_addr  = 32'h14;
      stepCycle();
      if_valid = 1'b0;
      stepCycle();

      // Continuous contention for 8 cycles yields 4 grants.
      grant_log.delete();
      if_valid = 1'b1;
      if_addr  = 32'h10;
      d_valid  = 1'b1;
      d_addr   = 32'h30;
      d_wmask  = 4'b0000;
      repeat (8) stepCycle();
      if_valid = 1'b0;
      d_valid  = 1'b0;
      checkOutput("cont_grants", 32'(grant_log.size()), 4);
      for (int i = 0; i < grant_log.size() && i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
         checkOutput($sformatf("cont_order%0d", i), 32'(grant_log[i]), 32'(i % 2 == 0));
`else
         checkOutput($sformatf("cont_order%0d", i), 32'(grant_log[i]), 1);
`endif
      end
      stepCycle();

      // Random two-port traffic.
      if_acc = 0;
      d_acc  = 0;
      repeat (800) begin
         applyStimulus();
         stepCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 6 KB `Memory` (1536 × 32-bit words, 1-cycle registered read, byte-masked write) between the CPU instruction-fetch port and the load/store data port. It sits between the processor core and `Memory`: it accepts one request per transaction, drives `mem_addr/mem_rstrb/mem_wdata/mem_wmask`, and returns read data or a write acknowledge to the winning requester. Out-of-range addresses are blocked and flagged, and per-port grant counters are kept for performance debug.

## Interface
Parameters:
- `MEM_WORDS`, 1536: number of 32-bit words behind the arbiter; a word index `>= MEM_WORDS` is out of range.
- `CNT_W`, 32: width of each grant counter.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_valid` in 1: instruction-fetch read request.
- `if_addr` in 32: fetch byte address.
- `if_ready` out 1: fetch request accepted this cycle.
- `if_rsp_valid` out 1: fetch response pulse.
- `if_rsp_rdata` out 32: fetch read data.
- `if_rsp_err` out 1: fetch address was out of range.
- `d_valid` in 1: data request.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_wmask` in 4: byte-write mask; `0000` means read.
- `d_ready` out 1: data request accepted this cycle.
- `d_rsp_valid` out 1: data response pulse (read data or write ack).
- `d_rsp_rdata` out 32: data read data.
- `d_rsp_err` out 1: data address was out of range.
- `mem_addr` out 32, `mem_rstrb` out 1, `mem_wdata` out 32, `mem_wmask` out 4: to `Memory`.
- `mem_rdata` in 32: from `Memory`.
- `if_grant_cnt` out CNT_W, `d_grant_cnt` out CNT_W: accepted-request counters.

## Operation
- FSM states: IDLE and RESP.
- IDLE with at least one valid request: select the winner combinationally, assert its `*_ready`, and drive the memory port. Go to RESP at the clock edge.
- IDLE with no request: no ready, `mem_rstrb=0`, `mem_wmask=0`.
- RESP: lasts exactly one cycle. Both readies are 0, memory strobes are 0, and the response pulse is asserted. Always return to IDLE.
- Memory drive on grant:
  - `mem_addr` is the winner's address.
  - Reads: `mem_rstrb=1`, `mem_wmask=0`.
  - Data writes: `mem_rstrb=0`, `mem_wmask=d_wmask`, `mem_wdata=d_wdata`.
  - `mem_wdata=0` whenever no data write is granted.
- Range check: word index is `addr[31:2]`. If it is `>= MEM_WORDS`, the request is still accepted and the response still follows one cycle later. However, `mem_rstrb` and `mem_wmask` stay 0, and the response carries `*_rsp_err=1` and `rdata=0`.
- Response data:
  - `*_rsp_rdata = mem_rdata` for an in-range read.
  - `*_rsp_rdata = 0` for writes and errors.
  - Only the port granted in the previous IDLE cycle pulses `*_rsp_valid`. Responses are not backpressured.
- Requesters hold valid, addr, wdata and wmask stable until ready is seen. Dropping valid before ready is legal and issues nothing.
- Address bits [1:0] are ignored; no misalignment checking.
- Counters increment by 1 on each accepted request, including error requests, and wrap modulo 2^CNT_W.

## Timing
- Request accepted in cycle N → memory samples at the edge ending N → response valid throughout cycle N+1.
- Peak throughput: one transaction per 2 cycles. Back-to-back requests from the same port are accepted in N, N+2, N+4, ...
- Reset values: state IDLE; all `*_rsp_valid`, `*_rsp_err`, `*_rsp_rdata`, and both counters are 0.
- While `reset` is high: `*_ready`, `mem_rstrb` and `mem_wmask` are forced to 0.
- Reset asserted in RESP: the response pulse is dropped immediately. An in-flight write that already reached memory is not undone.
- Simultaneous `if_valid` and `d_valid` in IDLE: resolved per Configuration. Exactly one ready is asserted.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A `last_grant` register, reset to ifetch, gives priority to the port not granted last. Under continuous contention, grants alternate d, if, d, if, ...
- `MEM_ARB_RR_EN` undefined: fixed priority, data port always wins. No `last_grant` register exists. Fetch may starve while `d_valid` is held high.

## Test plan
- Read: preload word 5 = 0xDEADBEEF; `if_valid`, `if_addr=0x14` → `if_ready` in N, `mem_rstrb=1`, `if_rsp_valid=1` and `if_rsp_rdata=0xDEADBEEF` in N+1, `if_grant_cnt=1`.
- Byte write: `d_addr=0x20`, `d_wmask=4'b0100`, `d_wdata=0x00AB0000` over word 0x11223344 → `d_rsp_valid` in N+1 with rdata 0. A following read returns 0x11AB3344.
- Out-of-range: `d_addr=0x1800` (word 1536), read → `mem_rstrb=0`, `d_rsp_err=1`, `d_rsp_rdata=0`, `d_grant_cnt` increments.
- Contention: both valid for 8 cycles → 4 grants.
  - With `MEM_ARB_RR_EN`: order d, if, d, if.
  - Without it: all four grants go to d, `if_grant_cnt=0`.
- Reset mid-operation: assert `reset` during RESP → `d_rsp_valid` goes to 0 in the same cycle, counters read 0, and the next request after deassertion completes normally.
